// File: rtl/fetch_irq_ctrl_if.sv
// Fetch-stage interrupt bus: requests, redirect window qualifiers and the
// redirect/acknowledge outputs of fetch_irq_ctrl.
interface fetch_irq_ctrl_if #(
    parameter int unsigned NUM_IRQ = 4
);
    logic [NUM_IRQ-1:0] irq_req;
    logic               irq_mask_we;
    logic [NUM_IRQ-1:0] irq_mask_wdata;
    logic               add_stall;
    logic               isbranchtaken_E;
    logic               bubble_D;
    logic [31:0]        pc_D;
    logic               reti_E;
    logic               interrupt;
    logic [31:0]        pc_isr;
    logic [NUM_IRQ-1:0] irq_ack;
    logic               in_isr;
    logic [31:0]        epc;
    logic               wait_timeout;

    modport master (
        output irq_req, irq_mask_we, irq_mask_wdata, add_stall, isbranchtaken_E,
               bubble_D, pc_D, reti_E,
        input  interrupt, pc_isr, irq_ack, in_isr, epc, wait_timeout
    );

    modport slave (
        input  irq_req, irq_mask_we, irq_mask_wdata, add_stall, isbranchtaken_E,
               bubble_D, pc_D, reti_E,
        output interrupt, pc_isr, irq_ack, in_isr, epc, wait_timeout
    );
endinterface

// File: rtl/fetch_irq_ctrl.sv
// Interrupt sequencer for the fetch stage: priority arbitration, safe redirect
// window wait, ISR vector redirect, epc save and replay on return.
// Optional macro IRQ_WAIT_TIMEOUT_EN: bounds the WAIT state with a timeout that
// forces the redirect (still blocked by a taken branch) and sets wait_timeout.
module fetch_irq_ctrl #(
    parameter int unsigned NUM_IRQ      = 4,
    parameter logic [31:0] ISR_BASE     = 32'h0000_0100,
    parameter logic [31:0] ISR_STRIDE   = 32'h0000_0010,
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    fetch_irq_ctrl_if.slave  bus
);
    localparam int unsigned IdW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [2:0] {StIdle, StWait, StFire, StService, StReturn} state_e;

    state_e             state_q, state_d;
    logic [IdW-1:0]     id_q, id_d, win_id;
    logic [NUM_IRQ-1:0] mask_q, mask_d, eligible;
    logic [31:0]        epc_q, epc_d;
    logic               wt_q, wt_d;
    logic               interrupt_q, interrupt_d;
    logic [31:0]        pc_isr_q, pc_isr_d;
    logic [NUM_IRQ-1:0] ack_q, ack_d;
    logic               in_isr_q, in_isr_d;
    logic               window_ok, go_fire;

`ifdef IRQ_WAIT_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_hit;

    // WAIT cycle counter: zero outside WAIT so it restarts on every WAIT entry
    always_comb begin
        timeout_hit = (state_q == StWait) && (cnt_q >= 8'(WAIT_TIMEOUT - 1));
        cnt_d       = 8'd0;
        if (state_q == StWait) begin
            cnt_d = (cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
        end
        wt_d = wt_q | timeout_hit;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 8'd0;
        else      cnt_q <= cnt_d;
    end
`else
    // No timeout: flag stays low
    always_comb begin
        wt_d = 1'b0;
    end
`endif

    // Arbitration (lowest index wins) and redirect window qualification
    always_comb begin
        eligible  = bus.irq_req & ~mask_q;
        win_id    = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) win_id = IdW'(i);
        end
        window_ok = !bus.add_stall && !bus.isbranchtaken_E && !bus.bubble_D;
`ifdef IRQ_WAIT_TIMEOUT_EN
        // A taken branch always blocks, even a forced timeout redirect
        go_fire   = !bus.isbranchtaken_E && (window_ok || timeout_hit);
`else
        go_fire   = window_ok;
`endif
    end

    // Next-state logic; id and epc are latched on the transitions that own them
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        epc_d   = epc_q;
        mask_d  = bus.irq_mask_we ? bus.irq_mask_wdata : mask_q;
        case (state_q)
            StIdle: begin
                if (|eligible) begin
                    id_d    = win_id;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (go_fire) begin
                    epc_d   = bus.pc_D;
                    state_d = StFire;
                end
            end
            StFire:    state_d = StService;
            StService: if (bus.reti_E) state_d = StReturn;
            StReturn:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        interrupt_d = 1'b0;
        pc_isr_d    = 32'd0;
        ack_d       = '0;
        in_isr_d    = 1'b0;
        case (state_d)
            StFire: begin
                interrupt_d = 1'b1;
                pc_isr_d    = ISR_BASE + 32'(id_d) * ISR_STRIDE;
                ack_d[id_d] = 1'b1;
            end
            StService: in_isr_d = 1'b1;
            StReturn: begin
                interrupt_d = 1'b1;
                pc_isr_d    = epc_q;
            end
            default: ;
        endcase
    end

    // State and output registers; reset masks every line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            id_q        <= '0;
            mask_q      <= '1;
            epc_q       <= 32'd0;
            wt_q        <= 1'b0;
            interrupt_q <= 1'b0;
            pc_isr_q    <= 32'd0;
            ack_q       <= '0;
            in_isr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            mask_q      <= mask_d;
            epc_q       <= epc_d;
            wt_q        <= wt_d;
            interrupt_q <= interrupt_d;
            pc_isr_q    <= pc_isr_d;
            ack_q       <= ack_d;
            in_isr_q    <= in_isr_d;
        end
    end

    assign bus.interrupt    = interrupt_q;
    assign bus.pc_isr       = pc_isr_q;
    assign bus.irq_ack      = ack_q;
    assign bus.in_isr       = in_isr_q;
    assign bus.epc          = epc_q;
    assign bus.wait_timeout = wt_q;
endmodule
